// File: rtl/pc_npc_branch_unit_pkg.sv
// Shared constants and types for the PC/nPC branch unit.
package pc_npc_branch_unit_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t      PC_RESET  = 32'h0000_0000;
  localparam addr_t      NPC_RESET = 32'h0000_0004;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BN   = 4'b0000;

  // Sequential successor; the add wraps at 2^32 and drops the carry.
  function automatic addr_t seq_next(input addr_t a);
    return a + addr_t'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/pc_npc_branch_unit_sat_counter16.sv
// 16-bit event counter with enable and synchronous clear; holds at 16'hFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= 16'h0000;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/pc_npc_branch_unit.sv
// SPARC-style PC/nPC sequencer with delayed branches, CALL redirect and annul.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module pc_npc_branch_unit
  import pc_npc_branch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_branch_instr,
  input  logic              branch_out,
  input  logic [3:0]        ID_cond,
  input  logic              ID_annul,
  input  logic [ADDR_W-1:0] ID_branch_target,
  input  logic              ID_call,
  input  logic [ADDR_W-1:0] ID_call_target,
  input  logic              hazard_stall,
`ifdef BRANCH_STATS_EN
  output logic [15:0]       stat_taken,
  output logic [15:0]       stat_not_taken,
`endif
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] nPC,
  output logic              ID_slot_annulled
);

  logic  annul_q;
  logic  annul_d;
  logic  valid_branch;
  logic  valid_call;
  addr_t npc_d;

  // An annulled delay slot is a NOP: it may neither redirect nor re-arm annul.
  assign valid_branch = ID_branch_instr && !annul_q;
  assign valid_call   = ID_call && !annul_q;

  always_comb begin
    npc_d = seq_next(nPC);
    if (valid_call) begin
      npc_d = ID_call_target;
    end else if (valid_branch && branch_out) begin
      npc_d = ID_branch_target;
    end
  end

  // BA with a=1 annuls even though taken; CALL never annuls.
  assign annul_d = valid_branch && ID_annul && (!branch_out || (ID_cond == COND_BA));

  always_ff @(posedge clk) begin
    if (reset) begin
      PC      <= PC_RESET;
      nPC     <= NPC_RESET;
      annul_q <= 1'b0;
    end else if (!hazard_stall) begin
      PC      <= nPC;
      nPC     <= npc_d;
      annul_q <= annul_d;
    end
  end

  assign ID_slot_annulled = annul_q;

`ifdef BRANCH_STATS_EN
  logic count_taken;
  logic count_not_taken;

  assign count_taken     = !hazard_stall && valid_branch && branch_out;
  assign count_not_taken = !hazard_stall && valid_branch && !branch_out;

  sat_counter16 u_stat_taken (
    .clk   (clk),
    .clear (reset),
    .en    (count_taken),
    .count (stat_taken)
  );

  sat_counter16 u_stat_not_taken (
    .clk   (clk),
    .clear (reset),
    .en    (count_not_taken),
    .count (stat_not_taken)
  );
`endif

endmodule

// File: tb/tb_pc_npc_branch_unit.sv
// Table-driven bench for pc_npc_branch_unit; statistics checks build only with BRANCH_STATS_EN.
module tb_pc_npc_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_branch_instr;
  logic        branch_out;
  logic [3:0]  ID_cond;
  logic        ID_annul;
  logic [31:0] ID_branch_target;
  logic        ID_call;
  logic [31:0] ID_call_target;
  logic        hazard_stall;
  logic [31:0] PC;
  logic [31:0] nPC;
  logic        ID_slot_annulled;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken;
  logic [15:0] stat_not_taken;
`endif

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  pc_npc_branch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .ID_branch_instr  (ID_branch_instr),
    .branch_out       (branch_out),
    .ID_cond          (ID_cond),
    .ID_annul         (ID_annul),
    .ID_branch_target (ID_branch_target),
    .ID_call          (ID_call),
    .ID_call_target   (ID_call_target),
    .hazard_stall     (hazard_stall),
`ifdef BRANCH_STATS_EN
    .stat_taken       (stat_taken),
    .stat_not_taken   (stat_not_taken),
`endif
    .PC               (PC),
    .nPC              (nPC),
    .ID_slot_annulled (ID_slot_annulled)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic        bo;
    logic [3:0]  cond;
    logic        an;
    logic [31:0] bt;
    logic        call;
    logic [31:0] ct;
    logic [31:0] epc;
    logic [31:0] enpc;
    logic        eann;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                              input logic bo, input logic [3:0] cond, input logic an,
                              input logic [31:0] bt, input logic call, input logic [31:0] ct,
                              input logic [31:0] epc, input logic [31:0] enpc,
                              input logic eann);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.bo = bo; v.cond = cond; v.an = an;
    v.bt = bt; v.call = call; v.ct = ct; v.epc = epc; v.enpc = enpc; v.eann = eann;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic apply(input vec_t v, input string tag);
    reset            = v.rst;
    hazard_stall     = v.stall;
    ID_branch_instr  = v.br;
    branch_out       = v.bo;
    ID_cond          = v.cond;
    ID_annul         = v.an;
    ID_branch_target = v.bt;
    ID_call          = v.call;
    ID_call_target   = v.ct;
    @(posedge clk);
    #1;
    check({tag, " PC"},  PC,  v.epc);
    check({tag, " nPC"}, nPC, v.enpc);
    check({tag, " annul"}, {31'b0, ID_slot_annulled}, {31'b0, v.eann});
  endtask

  initial begin
    //            rst st br bo cond    an bt            call ct            PC            nPC           ann
    tbl.push_back(mk(1, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h4,        0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h4,        32'h8,        0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h8,        32'hC,        0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'hC,        32'h10,       0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h4,        0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h4,        32'h8,        0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h8,        32'hC,        0));
    tbl.push_back(mk(0, 0, 1, 1, 4'h1, 0, 32'h40,       0, 32'h0,        32'hC,        32'h40,       0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h40,       32'h44,       0));
    tbl.push_back(mk(0, 0, 1, 0, 4'h1, 1, 32'h100,      0, 32'h0,        32'h44,       32'h48,       1));
    tbl.push_back(mk(0, 0, 1, 1, 4'h1, 1, 32'h200,      0, 32'h0,        32'h48,       32'h4C,       0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        1, 32'h300,      32'h4C,       32'h300,      0));
    tbl.push_back(mk(0, 0, 1, 1, 4'h8, 1, 32'h500,      0, 32'h0,        32'h300,      32'h500,      1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        1, 32'h700,      32'h500,      32'h504,      0));
    tbl.push_back(mk(0, 0, 1, 0, 4'h0, 1, 32'h900,      0, 32'h0,        32'h504,      32'h508,      1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h508,      32'h50C,      0));
    tbl.push_back(mk(0, 0, 1, 1, 4'h8, 0, 32'hA00,      0, 32'h0,        32'h50C,      32'hA00,      0));
    tbl.push_back(mk(0, 0, 1, 1, 4'h1, 0, 32'h2000,     1, 32'h1000,     32'hA00,      32'h1000,     0));
    tbl.push_back(mk(0, 0, 1, 0, 4'h1, 1, 32'h3000,     0, 32'h0,        32'h1000,     32'h1004,     1));
    tbl.push_back(mk(0, 1, 0, 0, 4'h1, 0, 32'h0,        1, 32'h5000,     32'h1000,     32'h1004,     1));
    tbl.push_back(mk(0, 1, 0, 0, 4'h1, 0, 32'h0,        1, 32'h5000,     32'h1000,     32'h1004,     1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h1004,     32'h1008,     0));
    tbl.push_back(mk(0, 1, 1, 1, 4'h1, 1, 32'h3000,     0, 32'h0,        32'h1004,     32'h1008,     0));
    tbl.push_back(mk(0, 1, 1, 1, 4'h1, 1, 32'h3000,     0, 32'h0,        32'h1004,     32'h1008,     0));
    tbl.push_back(mk(0, 0, 1, 1, 4'h1, 0, 32'h3000,     0, 32'h0,        32'h1008,     32'h3000,     0));
    tbl.push_back(mk(1, 1, 1, 1, 4'h1, 0, 32'h7000,     1, 32'h7100,     32'h0,        32'h4,        0));
    tbl.push_back(mk(0, 0, 1, 1, 4'h1, 0, 32'h13,       0, 32'h0,        32'h4,        32'h13,       0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h13,       32'h17,       0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h17,      32'hFFFF_FFFC, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 32'h0,       0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h4,        0));
    tbl.push_back(mk(0, 0, 1, 0, 4'h1, 1, 32'h80,       0, 32'h0,        32'h4,        32'h8,        1));
    tbl.push_back(mk(1, 0, 1, 1, 4'h1, 0, 32'h80,       0, 32'h0,        32'h0,        32'h4,        0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h1, 0, 32'h0,        1, 32'h90,       32'h0,        32'h4,        0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Back-to-back annul: the slot's branch is ignored, the one after it counts.
    apply(mk(0, 0, 0, 0, 4'h1, 0, 32'h0,   0, 32'h0, 32'h4,   32'h8,   0), "seqA0");
    apply(mk(0, 0, 1, 0, 4'h2, 1, 32'h60,  0, 32'h0, 32'h8,   32'hC,   1), "seqA1");
    apply(mk(0, 0, 1, 0, 4'h2, 1, 32'h60,  0, 32'h0, 32'hC,   32'h10,  0), "seqA2");
    apply(mk(0, 0, 1, 0, 4'h2, 1, 32'h60,  0, 32'h0, 32'h10,  32'h14,  1), "seqA3");
    apply(mk(0, 0, 1, 1, 4'h8, 1, 32'h800, 0, 32'h0, 32'h14,  32'h18,  0), "seqA4");
    apply(mk(0, 0, 1, 1, 4'h8, 1, 32'h800, 0, 32'h0, 32'h18,  32'h800, 1), "seqA5");

`ifdef BRANCH_STATS_EN
    apply(mk(1, 0, 0, 0, 4'h1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h4, 0), "st_rst");
    check("stat_taken reset",     {16'b0, stat_taken},     32'd0);
    check("stat_not_taken reset", {16'b0, stat_not_taken}, 32'd0);
    apply(mk(0, 0, 1, 1, 4'h1, 0, 32'h100, 0, 32'h0, 32'h4,   32'h100, 0), "st1");
    apply(mk(0, 0, 1, 1, 4'h1, 0, 32'h200, 0, 32'h0, 32'h100, 32'h200, 0), "st2");
    apply(mk(0, 1, 1, 1, 4'h1, 0, 32'h900, 0, 32'h0, 32'h100, 32'h200, 0), "st_stall");
    apply(mk(0, 0, 1, 1, 4'h1, 0, 32'h300, 0, 32'h0, 32'h200, 32'h300, 0), "st3");
    apply(mk(0, 0, 1, 0, 4'h1, 0, 32'h0,   0, 32'h0, 32'h300, 32'h304, 0), "st4");
    apply(mk(0, 0, 1, 0, 4'h1, 1, 32'h0,   0, 32'h0, 32'h304, 32'h308, 1), "st5");
    apply(mk(0, 0, 1, 1, 4'h1, 0, 32'h900, 0, 32'h0, 32'h308, 32'h30C, 0), "st6");
    check("stat_taken count",     {16'b0, stat_taken},     32'd3);
    check("stat_not_taken count", {16'b0, stat_not_taken}, 32'd2);
    reset = 1'b0; hazard_stall = 1'b0; ID_call = 1'b0; ID_branch_instr = 1'b1;
    branch_out = 1'b1; ID_annul = 1'b0; ID_cond = 4'h1; ID_branch_target = 32'h400;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    check("stat_taken saturate",      {16'b0, stat_taken},     32'h0000_FFFF);
    check("stat_not_taken unchanged", {16'b0, stat_not_taken}, 32'd2);
    @(posedge clk);
    #1;
    check("stat_taken hold", {16'b0, stat_taken}, 32'h0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/pc_npc_branch_unit.md
PC_NPC_BRANCH_UNIT -- requirements
Module: pc_npc_branch_unit

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-003 SHALL provide ID_branch_instr  input  1  Bicc instruction present in ID.
REQ-004 SHALL provide branch_out  input  1  taken decision from condition_handler, valid with ID_branch_instr.
REQ-005 SHALL provide ID_cond  input  4  Bicc cond field; used only for BA (1000) annul rule.
REQ-006 SHALL provide ID_annul  input  1  Bicc a-bit.
REQ-007 SHALL provide ID_branch_target  input  32  PC-relative target computed upstream.
REQ-008 SHALL provide ID_call, ID_call_target  input  1, 32  CALL present in ID and its target.
REQ-009 SHALL provide hazard_stall  input  1  freeze PC, nPC, annul state.
REQ-010 SHALL provide PC, nPC  output  32, 32  fetch address and next fetch address.
REQ-011 SHALL provide ID_slot_annulled  output  1  instruction now in ID is an annulled delay slot; treat as NOP.

Function
REQ-012 Non-stalled cycle SHALL load PC <= nPC; nPC <= redirect target or nPC+4 (32-bit wrap, no carry out).
REQ-013 Valid branch = ID_branch_instr && !ID_slot_annulled; valid call = ID_call && !ID_slot_annulled.
REQ-014 Redirect priority SHALL be: valid call (nPC <= ID_call_target) > valid branch with branch_out=1 (nPC <= ID_branch_target) > sequential.
REQ-015 On non-stalled cycle, annul register SHALL load 1 iff valid branch && ID_annul && (branch_out==0 || ID_cond==4'b1000); else 0.
REQ-016 ID_slot_annulled SHALL equal the annul register (one-cycle latency from branch in ID).
REQ-017 Annulled slot SHALL neither redirect nor re-arm annul, even if it decodes as branch/call.
REQ-018 BN with a=1 SHALL annul slot; BA with a=0 SHALL not annul; CALL SHALL never annul.
REQ-019 hazard_stall=1 SHALL hold PC, nPC, annul register, counters unchanged; branch/call inputs ignored that cycle.
REQ-020 Target low 2 bits SHALL be passed unmodified (no alignment checking).

Reset
REQ-021 reset=1 SHALL set PC=32'h0000_0000, nPC=32'h0000_0004, annul register=0, counters=0 at the next edge.
REQ-022 reset SHALL take priority over hazard_stall and any redirect in the same cycle.
REQ-023 Outputs SHALL reflect reset values from the first edge after reset assertion until deassertion.

Configuration
REQ-024 Macro BRANCH_STATS_EN SHALL, when defined, add outputs stat_taken and stat_not_taken (16 each).
REQ-025 With BRANCH_STATS_EN: non-stalled valid branch SHALL increment stat_taken when branch_out=1, else stat_not_taken; saturate at 16'hFFFF.
REQ-026 Without BRANCH_STATS_EN: counters and ports SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package SHALL hold PC_RESET, NPC_RESET, INSTR_BYTES (4), COND_BA, COND_BN, ADDR_W (32).
REQ-028 Counters SHALL use one sub-module, sat_counter16 (enable, sync clear, saturate), instantiated twice under BRANCH_STATS_EN.
REQ-029 PC/nPC/annul logic SHALL remain in the top module; no further sub-modules.

Verification
REQ-030 Reset 1 cycle, then 3 free cycles -> PC sequence 0,4,8,C; nPC 4,8,C,10; ID_slot_annulled=0.
REQ-031 At PC=8,nPC=C: branch taken, target 40, a=0 -> next PC=C,nPC=40; then PC=40,nPC=44; slot not annulled.
REQ-032 Branch not taken, a=1 -> nPC=nPC+4, ID_slot_annulled=1 next cycle; branch in that slot ignored.
REQ-033 BA (cond=1000) taken, a=1 -> nPC=target and ID_slot_annulled=1; BN a=1 -> sequential, annulled.
REQ-034 hazard_stall for 2 cycles during taken branch -> PC/nPC/annul frozen; redirect applies on first unstalled cycle; reset during stall -> PC=0,nPC=4.
REQ-035 BRANCH_STATS_EN: 3 taken + 2 not-taken + 1 annulled-slot branch -> stat_taken=3, stat_not_taken=2; preload to FFFF -> stays FFFF.
